// File: rtl/rejestr_wyniku.sv
// Result output stage: 2-entry buffer with per-entry status flags.
// Define REJESTR_WYNIKU_ERR_COUNTER_EN to build the saturating error counter.
module rejestr_wyniku #(
    parameter int BITS     = 32,
    parameter int CNT_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [BITS-1:0]     i_result,
    input  logic                i_error,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [BITS-1:0]     o_result,
    output logic [3:0]          o_flags,
    output logic [CNT_BITS-1:0] o_err_count,
    input  logic                i_clr_count
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [BITS-1:0] head_res_q;
    logic [BITS-1:0] tail_res_q;
    logic [3:0]      head_flg_q;
    logic [3:0]      tail_flg_q;
    logic            push;
    logic            pop;
    logic [3:0]      in_flags;

    assign o_ready  = (state_q != FULL);
    assign o_valid  = (state_q != EMPTY);
    assign push     = i_valid && o_ready;
    assign pop      = o_valid && i_ready;
    assign in_flags = {i_error, ^i_result, i_result[BITS-1], i_result == '0};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= EMPTY;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (pop && !push) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Head is cleared on drain so the outputs read zero while empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_res_q <= '0;
            head_flg_q <= '0;
            tail_res_q <= '0;
            tail_flg_q <= '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_res_q <= i_result;
                        head_flg_q <= in_flags;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_res_q <= i_result;
                        head_flg_q <= in_flags;
                    end else if (push) begin
                        tail_res_q <= i_result;
                        tail_flg_q <= in_flags;
                    end else if (pop) begin
                        head_res_q <= '0;
                        head_flg_q <= '0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_res_q <= tail_res_q;
                        head_flg_q <= tail_flg_q;
                    end
                end
                default: begin
                    head_res_q <= '0;
                    head_flg_q <= '0;
                end
            endcase
        end
    end

    assign o_result = head_res_q;
    assign o_flags  = head_flg_q;

`ifdef REJESTR_WYNIKU_ERR_COUNTER_EN
    logic [CNT_BITS-1:0] cnt_q;
    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            cnt_q <= '0;
        else if (i_clr_count)
            cnt_q <= '0;
        else if (push && i_error && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_ONE;
    end

    assign o_err_count = cnt_q;
`else
    logic unused_clr;
    assign unused_clr  = i_clr_count;
    assign o_err_count = '0;
`endif

endmodule

// File: tb/tb_rejestr_wyniku.sv
// Bench for rejestr_wyniku: queue model compared every cycle plus
// hand-computed directed expectations.
module tb_rejestr_wyniku;

    localparam int BITS     = 32;
    localparam int CNT_BITS = 8;
    localparam int CNT_MAX  = (1 << CNT_BITS) - 1;

    logic                i_clk = 1'b0;
    logic                i_rst_n;
    logic                i_valid;
    logic                o_ready;
    logic [BITS-1:0]     i_result;
    logic                i_error;
    logic                o_valid;
    logic                i_ready;
    logic [BITS-1:0]     o_result;
    logic [3:0]          o_flags;
    logic [CNT_BITS-1:0] o_err_count;
    logic                i_clr_count;

    rejestr_wyniku #(.BITS(BITS), .CNT_BITS(CNT_BITS)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_result    (i_result),
        .i_error     (i_error),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_flags     (o_flags),
        .o_err_count (o_err_count),
        .i_clr_count (i_clr_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [BITS-1:0] r;
        logic            e;
    } ent_t;

    ent_t mq[$];
    int   mcnt;
    int   checks = 0;
    int   errors = 0;
    bit   run    = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] flags_of(input ent_t x);
        logic [3:0] f;
        f[0] = (x.r == 0);
        f[1] = x.r[BITS-1];
        f[2] = ($countones(x.r) % 2) == 1;
        f[3] = x.e;
        return f;
    endfunction

    always @(negedge i_rst_n) begin
        mq.delete();
        mcnt = 0;
    end

    always @(posedge i_clk) begin
        if (i_rst_n) begin
            bit pu;
            bit po;
            pu = i_valid && (mq.size() < 2);
            po = (mq.size() > 0) && i_ready;
            if (po) void'(mq.pop_front());
            if (pu) mq.push_back('{r: i_result, e: i_error});
            if (i_clr_count)
                mcnt = 0;
            else if (pu && i_error && mcnt < CNT_MAX)
                mcnt = mcnt + 1;
        end
    end

    always @(negedge i_clk) begin
        if (run) begin
            ent_t h;
            h = '{r: '0, e: 1'b0};
            check("m_valid", 64'(o_valid), 64'(mq.size() != 0));
            check("m_ready", 64'(o_ready), 64'(mq.size() < 2));
            if (mq.size() != 0) h = mq[0];
            check("m_result", 64'(o_result), 64'(h.r));
            check("m_flags", 64'(o_flags),
                  (mq.size() != 0) ? 64'(flags_of(h)) : 64'd0);
`ifdef REJESTR_WYNIKU_ERR_COUNTER_EN
            check("m_errcnt", 64'(o_err_count), 64'(mcnt));
`else
            check("m_errcnt", 64'(o_err_count), 64'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_valid     = 1'b0;
        i_result    = '0;
        i_error     = 1'b0;
        i_ready     = 1'b0;
        i_clr_count = 1'b0;
        run         = 1'b1;
        repeat (3) tick();
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_result", 64'(o_result), 64'd0);
        check("rst_flags", 64'(o_flags), 64'd0);
        check("rst_errcnt", 64'(o_err_count), 64'd0);

        // single zero entry
        i_ready  = 1'b1;
        i_valid  = 1'b1;
        i_result = 32'h0;
        tick();
        i_valid = 1'b0;
        @(negedge i_clk);
        check("single_valid", 64'(o_valid), 64'd1);
        check("single_result", 64'(o_result), 64'd0);
        check("single_flags", 64'(o_flags), 64'b0001);
        tick();
        @(negedge i_clk);
        check("single_drain", 64'(o_valid), 64'd0);

        // backpressure
        i_ready  = 1'b0;
        i_valid  = 1'b1;
        i_result = 32'h8000_0001;
        tick();
        i_result = 32'h0000_0003;
        tick();
        i_result = 32'h5;
        @(negedge i_clk);
        check("bp_ready", 64'(o_ready), 64'd0);
        check("bp_head", 64'(o_result), 64'h8000_0001);
        check("bp_flags", 64'(o_flags), 64'b0010);
        tick();
        i_valid = 1'b0;
        @(negedge i_clk);
        check("bp_hold", 64'(o_result), 64'h8000_0001);
        i_ready = 1'b1;
        tick();
        @(negedge i_clk);
        check("bp_second", 64'(o_result), 64'h3);
        check("bp_second_fl", 64'(o_flags), 64'b0000);
        tick();
        @(negedge i_clk);
        check("bp_empty", 64'(o_valid), 64'd0);

        // streaming 1..10
        for (int k = 1; k <= 10; k++) begin
            i_valid  = 1'b1;
            i_result = k;
            tick();
            @(negedge i_clk);
            check("st_result", 64'(o_result), 64'(k));
            check("st_parity", 64'(o_flags[2]),
                  64'(k == 1 || k == 2 || k == 4 || k == 7 || k == 8));
        end
        i_valid = 1'b0;
        tick();

        // error counter
        i_valid = 1'b1;
        i_error = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_result = 32'hE0 + k;
            tick();
        end
        i_valid = 1'b0;
        i_error = 1'b0;
        @(negedge i_clk);
        check("err_flag", 64'(o_flags[3]), 64'd1);
`ifdef REJESTR_WYNIKU_ERR_COUNTER_EN
        check("err_three", 64'(o_err_count), 64'd3);
`else
        check("err_three", 64'(o_err_count), 64'd0);
`endif
        i_valid     = 1'b1;
        i_error     = 1'b1;
        i_clr_count = 1'b1;
        tick();
        i_valid     = 1'b0;
        i_error     = 1'b0;
        i_clr_count = 1'b0;
        @(negedge i_clk);
        check("err_clr_wins", 64'(o_err_count), 64'd0);
        i_valid = 1'b1;
        i_error = 1'b1;
        for (int k = 0; k < 260; k++) begin
            i_result = k;
            tick();
        end
        i_valid = 1'b0;
        i_error = 1'b0;
        @(negedge i_clk);
`ifdef REJESTR_WYNIKU_ERR_COUNTER_EN
        check("err_sat", 64'(o_err_count), 64'd255);
`else
        check("err_sat", 64'(o_err_count), 64'd0);
`endif
        repeat (2) tick();

        // reset while full
        i_ready  = 1'b0;
        i_valid  = 1'b1;
        i_result = 32'hAA;
        tick();
        i_result = 32'hBB;
        tick();
        i_valid = 1'b0;
        @(negedge i_clk);
        check("mid_full", 64'(o_ready), 64'd0);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("mid_valid", 64'(o_valid), 64'd0);
        check("mid_ready", 64'(o_ready), 64'd1);
        check("mid_result", 64'(o_result), 64'd0);
        tick();
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        repeat (2) tick();
        @(negedge i_clk);
        check("post_valid", 64'(o_valid), 64'd0);
        check("post_result", 64'(o_result), 64'd0);

        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rejestr_wyniku.md
# rejestr_wyniku

- Output stage of the execution unit.
- Captures each result word and error bit produced by the operation units (bit set, shifts, arithmetic) in a 2-entry buffer with valid/ready handshaking.
- Computes status flags for each captured word.
- Optionally counts results that carried an error.

## Interface

Parameters:
- BITS, 32, result word width.
- CNT_BITS, 8, error counter width.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_valid  in  1  upstream result valid.
- o_ready  out  1  stage can accept an entry.
- i_result  in  BITS  result word from the operation unit.
- i_error  in  1  error bit from the operation unit.
- o_valid  out  1  head entry valid.
- i_ready  in  1  downstream consumes the head entry.
- o_result  out  BITS  head result word.
- o_flags  out  4  head flags: [0] zero, [1] sign, [2] parity, [3] error.
- o_err_count  out  CNT_BITS  accepted-error counter.
- i_clr_count  in  1  synchronous counter clear.

## Operation

- Push occurs when i_valid && o_ready. Pop occurs when o_valid && i_ready.
- Flags are computed at push time and stored with the entry:
  - zero = (i_result == 0)
  - sign = i_result[BITS-1]
  - parity = XOR-reduction of i_result (1 = odd number of ones)
  - error = i_error
- i_result is stored unmodified, including when i_error = 1.
- Occupancy state machine:
  - EMPTY: push → ONE.
  - ONE: push only → FULL; pop only → EMPTY; push and pop together → stays ONE, new entry becomes head.
  - FULL: pop → ONE. A push is impossible because o_ready = 0.
- o_ready = (state != FULL). It depends on registered occupancy only, so there is no combinational path from i_ready.
- o_valid = (state != EMPTY).
- Entries leave in strict FIFO order.
- When i_valid is high while o_ready is low, the input is ignored. Upstream must hold it.
- When o_valid is high while i_ready is low, o_result and o_flags hold stable.
- When EMPTY, o_result = 0 and o_flags = 0.

Error counter:
- Increments by 1 on each push with i_error = 1.
- Saturates at 2^CNT_BITS-1; no wrap.
- i_clr_count forces 0 on the next edge. Clear wins over a same-cycle increment.

Reset:
- Asynchronous, takes effect immediately, including mid-operation. Buffered entries are discarded.
- Reset values: state EMPTY, o_valid 0, o_ready 1, o_result 0, o_flags 0, o_err_count 0.

## Timing

- Latency: an entry pushed at edge N drives o_valid/o_result from edge N onward, i.e. visible in cycle N+1.
- Throughput: 1 entry per cycle when i_ready is held high. The stage never leaves FULL/EMPTY bubbles.
- Backpressure: two consecutive pushes with i_ready low reach FULL. o_ready is low starting the cycle after the second push.
- Leaving FULL: a pop at edge M raises o_ready in cycle M+1.
- All outputs are registered except o_ready and o_valid. Those two are decoded directly from the state register.

## Configuration

- Macro: REJESTR_WYNIKU_ERR_COUNTER_EN.
- Defined: error counter present and behaves as described in Operation.
- Undefined: no counter logic is built. o_err_count is tied to 0, i_clr_count is ignored, and all other behaviour is identical.

## Test plan

- Reset: hold i_rst_n = 0, then release → o_valid = 0, o_ready = 1, o_result = 0, o_flags = 4'b0000, o_err_count = 0.
- Single entry: i_ready = 1, push i_result = 0x00000000, i_error = 0 → next cycle o_valid = 1, o_result = 0, o_flags = 4'b0001; the cycle after, o_valid = 0.
- Backpressure:
  - With i_ready = 0, push 0x80000001 then 0x00000003, then a third word 0x5 → o_ready = 0, 0x5 is not taken.
  - Head holds 0x80000001 with o_flags = 4'b0010.
  - Raise i_ready → 0x80000001 then 0x00000003 with o_flags = 4'b0000.
- Streaming: i_ready = 1, push 10 consecutive words 1..10 → outputs 1..10 on 10 consecutive cycles, one cycle after each push. Parity flag is 1 for words 1, 2, 4, 7, 8.
- Error counter (macro defined):
  - Push 3 entries with i_error = 1 → o_err_count = 3.
  - With CNT_BITS = 2, push 5 error entries → o_err_count saturates at 3.
  - Pulse i_clr_count together with an error push → o_err_count = 0.
- Reset mid-operation: fill to FULL, then assert i_rst_n = 0 between edges → o_valid drops and o_ready rises without a clock edge. After release the stage is empty and no stale entry appears.
